muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  EX-stage controller for the shared multiply/divide resources and the HI/LO register pair.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives the multicycle multiplier and divider,
//    stalls the pipeline while they run, and commits results to HI/LO.
//  - Serialises use: exactly one operation in flight at a time.
// PARAMETERS
//  DRAIN_CYC  1    idle cycles with mul_en/div_en low after any completion/abort (min 1)
//  TIMEOUT    64   watchdog limit in busy cycles (used only with MULDIV_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  op_valid   in   1   EX holds a muldiv-class instruction
//  op_code    in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = no-op
//  rs_val     in   32  operand A / dividend / MTHI-MTLO source
//  rt_val     in   32  operand B / divisor
//  flush      in   1   pipeline flush (exception/branch kill)
//  stall      out  1   hold EX and earlier stages
//  hi, lo     out  32  architectural HI/LO
//  mul_en     out  1   multiplier enable (held for the whole operation)
//  mul_unsign out  1   multiplier unsigned select
//  mul_a,mul_b out 32  latched multiplier operands
//  mul_result in   64  {HI,LO} product
//  mul_done   in   1   multiplier done (may stay high up to 2 cycles)
//  div_en,div_unsign,div_a,div_b  out 1/1/32/32  divider equivalents
//  div_quot,div_rem  in 32/32   quotient -> LO, remainder -> HI
//  div_done   in   1   divider done
//  err        out  1   watchdog abort sticky flag (0 when MULDIV_TIMEOUT_EN undefined)
// BEHAVIOUR
//  Reset (async): state=IDLE, hi=lo=0, all en=0, operand regs=0, err=0, drain cnt=0.
//  FSM: IDLE -> MUL_BUSY | DIV_BUSY -> DRAIN -> IDLE.
//  - IDLE, op_valid & !flush:
//    - MULT/MULTU: latch rs/rt into mul_a/mul_b, set unsign, -> MUL_BUSY.
//    - DIV/DIVU, rt_val!=0: latch into div_a/div_b -> DIV_BUSY.
//    - DIV/DIVU, rt_val==0: no divider use; commit HI=rs_val, LO=32'hFFFF_FFFF at this
//      edge; -> DRAIN.
//    - MTHI/MTLO: write hi/lo at this edge; stay IDLE; no stall.
//  - mul_en=1 exactly in MUL_BUSY; div_en=1 exactly in DIV_BUSY; operands stable throughout.
//  - BUSY & done: {hi,lo}<=mul_result (or hi<=div_rem, lo<=div_quot) on that edge; -> DRAIN.
//  - DRAIN: en low for DRAIN_CYC cycles, ignore stale done, then IDLE.
//  - stall (combinational) = (IDLE & op_valid & op is MULT..DIVU & !flush)
//    | (BUSY & !done) | DRAIN. Stall drops in the cycle done is seen, so the next
//    instruction advances as HI/LO commits.
//  - Next MFHI/MFLO reads committed hi/lo (registered, visible the cycle after commit).
//  - flush in BUSY: abort, en drops next edge, HI/LO unchanged, -> DRAIN.
//    flush in IDLE suppresses acceptance.
//  - flush and done in the same cycle: flush wins; no commit.
//  - Async reset mid-operation: immediate return to reset values; en drops without clk.
//  - Unknown op_code with op_valid: ignored, no stall.
// CONFIGURATION
//  MULDIV_TIMEOUT_EN defined: 7-bit busy counter; on reaching TIMEOUT without done,
//    abort as flush, set err=1 (sticky until reset), HI/LO unchanged.
//  Undefined: no counter; err tied 0; BUSY waits indefinitely for done.
// TESTING
//  - MULT rs=-3, rt=7; mul_done 5 cycles later -> mul_en high 5 cycles, hi=FFFFFFFF,
//    lo=FFFFFFEB, stall high until done cycle, one DRAIN cycle.
//  - DIVU rs=100, rt=7 -> lo=14, hi=2; DIV rs=5, rt=0 -> hi=5, lo=FFFFFFFF,
//    div_en never asserted.
//  - MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, stall never asserted.
//  - MULTU busy, flush at cycle 2 -> mul_en low next edge, HI/LO unchanged, late
//    mul_done ignored in DRAIN.
//  - flush and mul_done same cycle -> no commit; back-to-back MULT, DIV -> both commit,
//    DRAIN between them.
//  - TIMEOUT_EN, TIMEOUT=8, done never asserted -> abort after 8 busy cycles, err=1;
//    rst_n low mid-op -> all outputs reset.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier/divider and the HI/LO pair.
// Optional busy watchdog enabled by defining MULDIV_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no operation in flight, MTHI/MTLO and new ops accepted
// MUL_BUSY | multiplier running, mul_en high, waiting for mul_done
// DIV_BUSY | divider running, div_en high, waiting for div_done
// DRAIN    | enables low for DRAIN_CYC cycles, stale done ignored
module muldiv_ctrl #(
  parameter int DRAIN_CYC = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_en,
  output logic        mul_unsign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  input  logic        mul_done,
  output logic        div_en,
  output logic        div_unsign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  input  logic        div_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DRAIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  if (DRAIN_CYC < 1 || DRAIN_CYC > 256 || TIMEOUT < 1 || TIMEOUT > 128) begin : g_bad_param
    $error("muldiv_ctrl: DRAIN_CYC must be 1..256 and TIMEOUT 1..128");
  end

  state_t     state, state_nxt;
  logic [7:0] drain_cnt;
  logic       is_mul_op, is_div_op, accept, busy, done, tmo, abort, commit;

  assign is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign is_div_op = (op_code == OP_DIV)  || (op_code == OP_DIVU);
  assign accept    = (state == IDLE) && op_valid && !flush;
  assign busy      = (state == MUL_BUSY) || (state == DIV_BUSY);
  assign done      = ((state == MUL_BUSY) && mul_done) || ((state == DIV_BUSY) && div_done);
  // A flush (or watchdog expiry) beats a done arriving in the same cycle.
  assign abort     = busy && (flush || tmo);
  assign commit    = busy && done && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul_op)      state_nxt = MUL_BUSY;
        else if (accept && is_div_op) state_nxt = (rt_val == 32'd0) ? DRAIN : DIV_BUSY;
      end
      MUL_BUSY, DIV_BUSY: begin
        if (abort || done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_en = (state == MUL_BUSY);
    div_en = (state == DIV_BUSY);
    stall  = (accept && (is_mul_op || is_div_op)) || (busy && !done) || (state == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= '0;
      lo         <= '0;
      mul_unsign <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      div_unsign <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      drain_cnt  <= '0;
    end else begin
      if (accept) begin
        if (is_mul_op) begin
          mul_a      <= rs_val;
          mul_b      <= rt_val;
          mul_unsign <= (op_code == OP_MULTU);
        end else if (is_div_op && rt_val == 32'd0) begin
          hi <= rs_val;
          lo <= 32'hFFFF_FFFF;
        end else if (is_div_op) begin
          div_a      <= rs_val;
          div_b      <= rt_val;
          div_unsign <= (op_code == OP_DIVU);
        end else if (op_code == OP_MTHI) begin
          hi <= rs_val;
        end else if (op_code == OP_MTLO) begin
          lo <= rs_val;
        end
      end else if (commit) begin
        if (state == MUL_BUSY) begin
          {hi, lo} <= mul_result;
        end else begin
          hi <= div_rem;
          lo <= div_quot;
        end
      end
      if (state_nxt == DRAIN && state != DRAIN) drain_cnt <= 8'(DRAIN_CYC - 1);
      else if (state == DRAIN && drain_cnt != 8'd0) drain_cnt <= drain_cnt - 8'd1;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  logic [6:0] busy_cnt;

  // Loaded on acceptance; reaching zero in a busy cycle without done aborts.
  assign tmo = busy && !done && (busy_cnt == 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) busy_cnt <= 7'(TIMEOUT - 1);
      else if (busy && busy_cnt != 7'd0) busy_cnt <= busy_cnt - 7'd1;
      if (tmo) err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random op mix
// against an arithmetic HI/LO model; the bench plays the multiplier/divider.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        stall;
  logic [31:0] hi, lo;
  logic        mul_en, mul_unsign;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        mul_done;
  logic        div_en, div_unsign;
  logic [31:0] div_a, div_b;
  logic [31:0] div_quot, div_rem;
  logic        div_done;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_ctrl #(.DRAIN_CYC(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .hi(hi), .lo(lo), .mul_en(mul_en), .mul_unsign(mul_unsign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_done(mul_done),
    .div_en(div_en), .div_unsign(div_unsign), .div_a(div_a), .div_b(div_b),
    .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {HI,LO} an architecturally correct unit would produce
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint q, r, p;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = ua / ub; r = ua % ub; p = {r[31:0], q[31:0]};
      end
      default: p = 0;
    endcase
    return p;
  endfunction

  // Issue a MULT..DIVU with nonzero divisor; done after lat busy cycles, optional flush.
  task automatic t_busy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int flush_at, input bit hold);
    logic [63:0] r;
    bit is_mul, fin_done, fin_flush;
    int last, en_cnt, other_cnt;
    r = model(op, a, b);
    is_mul = (op < 3'd2);
    last = (flush_at != 0 && flush_at < lat) ? flush_at : lat;
    fin_done  = (last == lat);
    fin_flush = (flush_at == last);
    en_cnt = 0; other_cnt = 0;
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
    #1 check("accept_stall", stall, 1);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      en_cnt    += is_mul ? int'(mul_en) : int'(div_en);
      other_cnt += is_mul ? int'(div_en) : int'(mul_en);
      if (c == 1) begin
        if (is_mul) begin
          check("mul_a", mul_a, a); check("mul_b", mul_b, b);
          check("mul_unsign", mul_unsign, op == 3'd1);
        end else begin
          check("div_a", div_a, a); check("div_b", div_b, b);
          check("div_unsign", div_unsign, op == 3'd3);
        end
      end
      if (c == last) begin
        if (fin_done && is_mul) begin mul_done = 1'b1; mul_result = r; end
        if (fin_done && !is_mul) begin div_done = 1'b1; div_quot = r[31:0]; div_rem = r[63:32]; end
        flush = fin_flush;
      end
      #1 check("busy_stall", stall, !(c == last && fin_done));
    end
    if (fin_done && !fin_flush) begin exp_hi = r[63:32]; exp_lo = r[31:0]; end
    @(negedge clk);
    flush = 1'b0;
    check("en_cycles", en_cnt, last);
    check("other_en", other_cnt, 0);
    check("drain_en", mul_en | div_en, 0);
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    if (hold || !fin_done) begin
      mul_done = 1'b1; div_done = 1'b1;
      mul_result = ~r; div_quot = ~r[31:0]; div_rem = ~r[63:32];
    end else begin
      mul_done = 1'b0; div_done = 1'b0;
    end
    op_valid = 1'b1; op_code = 3'd0;
    #1 check("drain_stall", stall, 1);
    @(negedge clk);
    mul_done = 1'b0; div_done = 1'b0; op_valid = 1'b0;
    check("drain_hi", hi, exp_hi);
    check("drain_lo", lo, exp_lo);
    check("drain_no_accept", mul_en, 0);
    #1 check("idle_stall", stall, 0);
  endtask

  task automatic t_div0(input logic [2:0] op, input logic [31:0] a);
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = 32'd0;
    #1 check("div0_stall", stall, 1);
    @(negedge clk);
    exp_hi = a; exp_lo = 32'hFFFF_FFFF;
    check("div0_hi", hi, exp_hi);
    check("div0_lo", lo, exp_lo);
    check("div0_en", div_en, 0);
    check("div0_drain_stall", stall, 1);
    op_valid = 1'b0;
    @(negedge clk);
    check("div0_en2", div_en, 0);
    #1 check("div0_idle_stall", stall, 0);
  endtask

  task automatic t_mt(input logic [2:0] op, input logic [31:0] a);
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = ~a;
    #1 check("mt_stall", stall, 0);
    @(negedge clk);
    if (op == 3'd4) exp_hi = a; else exp_lo = a;
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
    op_valid = 1'b0;
  endtask

  // Op that must have no effect: unknown code, or a valid op killed by flush in IDLE.
  task automatic t_nop(input logic [2:0] op, input logic [31:0] a, input bit fl);
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = a ^ 32'h5A5A_0001; flush = fl;
    #1 check("nop_stall", stall, 0);
    @(negedge clk);
    check("nop_hi", hi, exp_hi);
    check("nop_lo", lo, exp_lo);
    check("nop_en", mul_en | div_en, 0);
    op_valid = 1'b0; flush = 1'b0;
    #1 check("nop_idle_stall", stall, 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int kind;
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0; flush = 1'b0;
    mul_result = '0; mul_done = 1'b0; div_quot = '0; div_rem = '0; div_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0); check("rst_lo", lo, 0);
    check("rst_en", {mul_en, div_en}, 0); check("rst_stall", stall, 0);
    check("rst_err", err, 0); check("rst_ops", {mul_a, div_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    t_busy(3'd0, 32'hFFFF_FFFD, 32'd7, 5, 0, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    t_busy(3'd3, 32'd100, 32'd7, 3, 0, 1'b1);
    check("divu_lo_const", lo, 32'd14);
    check("divu_hi_const", hi, 32'd2);
    t_div0(3'd2, 32'd5);
    t_mt(3'd4, 32'h1234);
    check("mthi_const", hi, 32'h1234);
    t_mt(3'd5, 32'hCAFE_0001);
    t_busy(3'd1, 32'h8000_0001, 32'hFFFF_FFFF, 6, 2, 1'b0);
    t_busy(3'd0, 32'd1234, 32'hFFFF_0000, 3, 3, 1'b1);
    t_busy(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0, 1'b0);
    t_busy(3'd2, 32'hFFFF_FF9C, 32'd7, 2, 0, 1'b0);
    t_nop(3'd6, 32'hDEAD_BEEF, 1'b0);
    t_nop(3'd7, 32'h0BAD_F00D, 1'b0);
    t_nop(3'd0, 32'h0000_0003, 1'b1);
    t_nop(3'd4, 32'h0000_0009, 1'b1);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      op = 3'(kind);
      if (kind <= 3) begin
        if (kind >= 2 && $urandom_range(0, 5) == 0) t_div0(op, a);
        else begin
          if (b == 0) b = 32'd3;
          t_busy(op, a, b, int'($urandom_range(1, 6)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
                 1'($urandom_range(0, 1)));
        end
      end else if (kind <= 5) t_mt(op, a);
      else t_nop(3'(6 + $urandom_range(0, 1)), a, 1'($urandom_range(0, 1)));
    end

`ifdef MULDIV_TIMEOUT_EN
    op_valid = 1'b1; op_code = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("tmo_busy_en", mul_en, 1);
    end
    @(negedge clk);
    op_valid = 1'b0;
    check("tmo_en", mul_en, 0); check("tmo_err", err, 1);
    check("tmo_hi", hi, exp_hi); check("tmo_lo", lo, exp_lo);
    @(negedge clk);
    check("tmo_err_sticky", err, 1);
`else
    check("err_tied", err, 0);
`endif

    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd11; rt_val = 32'd13;
    repeat (2) @(negedge clk);
    check("pre_rst_en", mul_en, 1);
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    check("arst_en", mul_en, 0); check("arst_stall", stall, 0);
    check("arst_hi", hi, 0); check("arst_lo", lo, 0);
    check("arst_mul_a", mul_a, 0); check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t_busy(3'd3, 32'hFFFF_FFFF, 32'd16, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
